// File: rtl/usr_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
package usr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_e;

    // Bit counter width able to hold 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/usr_deser_shifter.sv
// Direction-aware shift register with synchronous clear; exposes both the
// registered value and the combinational next value.
module usr_deser_shifter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         dir_i,
    input  logic         din_i,
    output logic [N-1:0] q_o,
    output logic [N-1:0] nxt_o
);

    logic [N-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (en_i) begin
            sr_d = dir_i ? {sr_q[N-2:0], din_i} : {din_i, sr_q[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) sr_q <= '0;
        else              sr_q <= sr_d;
    end

    assign q_o   = sr_q;
    assign nxt_o = sr_d;

endmodule

// File: rtl/usr_deserializer.sv
// Serial-to-parallel receiver with valid/ready on both sides.
// Optional trailing even-parity bit and perr flag: define USR_DESER_PARITY_EN.
module usr_deserializer
    import usr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         S,
    input  logic         ser_in,
    input  logic         ser_vld,
    output logic         ser_rdy,
    output logic [N-1:0] D_out,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic         busy
`ifdef USR_DESER_PARITY_EN
    ,
    output logic         perr
`endif
);

`ifdef USR_DESER_PARITY_EN
    localparam int W = N + 1;
`else
    localparam int W = N;
`endif
    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    deser_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          vld_q, vld_d;
    logic [N-1:0]  sr_q, sr_nxt;
    logic          last_bit, accept, complete, shift_en, cur_dir;

    assign last_bit = (cnt_q == LAST);
    // Only the word-completing bit can stall, and only while the held word is stuck.
    assign ser_rdy  = !(last_bit && vld_q && !out_rdy);
    assign accept   = ser_vld && ser_rdy;
    assign complete = accept && last_bit;
    assign cur_dir  = (state_q == IDLE) ? S : dir_q;

`ifdef USR_DESER_PARITY_EN
    // Parity bit is consumed by the check, never shifted; sr_nxt then equals sr_q.
    assign shift_en = accept && !last_bit;
`else
    assign shift_en = accept;
`endif

    usr_deser_shifter #(.N(N)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (complete),
        .en_i  (shift_en),
        .dir_i (cur_dir),
        .din_i (ser_in),
        .q_o   (sr_q),
        .nxt_o (sr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        dout_d  = dout_q;
        vld_d   = vld_q && !out_rdy;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dir_d   = S;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    if (last_bit) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (complete) begin
            dout_d = sr_nxt;
            vld_d  = 1'b1;
        end
    end

`ifdef USR_DESER_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk) begin
        if (rst)           perr_q <= 1'b0;
        else if (complete) perr_q <= (^sr_q) ^ ser_in;
    end
    assign perr = perr_q;
`endif

    assign D_out   = dout_q;
    assign out_vld = vld_q;
    assign busy    = (state_q == SHIFT);

endmodule
